// File: rtl/seq_detect_prog_if.sv
// Bus bundle for the programmable serial sequence detector: configuration
// write port, qualified serial input and detector outputs.
interface seq_detect_prog_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 5,
  parameter int unsigned CNT_W   = 8
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               y;
  logic               y_q;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_count;

  // Stimulus side: drives configuration and serial data, observes results.
  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    input  y, y_q, cfg_err, match_count
  );

  // Detector side.
  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    output y, y_q, cfg_err, match_count
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector. Compares the last len bits of the
// qualified serial stream against a right-aligned pattern, with selectable
// overlapping / non-overlapping matching and a saturating match counter.
module seq_detect_prog #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = 5,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1101),
  parameter int unsigned        DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seq_detect_prog_if.slave bus
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   count_q;
  logic               y_dly_q;
  logic               cfg_err_q;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] cand;
  logic               accept;
  logic               hit;
  logic               cfg_ok;

  // Length mask, candidate window and Mealy match decision.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (i < int'(len_q));
    end
    cand   = {hist_q[MAX_LEN-2:0], bus.din};
    // A config write steals the cycle, so its din bit is never looked at.
    accept = bus.din_valid && !bus.cfg_we && !rst;
    hit    = accept && (fill_q >= len_q - LEN_W'(1)) &&
             ((cand & mask) == (pattern_q & mask));
    cfg_ok = (bus.cfg_len >= LEN_W'(2)) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  end

  // Reset, configuration writes and history / counter updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      y_dly_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      y_dly_q   <= hit;
      if (bus.cfg_we) begin
        if (cfg_ok) begin
          pattern_q <= bus.cfg_pattern;
          len_q     <= bus.cfg_len;
          overlap_q <= bus.cfg_overlap;
          hist_q    <= '0;
          fill_q    <= '0;
          count_q   <= '0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end else if (bus.din_valid) begin
        hist_q <= cand;
        // Non-overlapping: forget the matched bits by restarting the fill.
        if (hit && !overlap_q) begin
          fill_q <= '0;
        end else if (fill_q != LEN_W'(MAX_LEN)) begin
          fill_q <= fill_q + LEN_W'(1);
        end
        if (hit && (count_q != '1)) begin
          count_q <= count_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.y           = hit;
  assign bus.y_q         = y_dly_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: reset defaults, overlap modes,
// reprogramming, illegal writes, write/data collisions, gaps, mid-pattern
// reset and counter saturation.
module tb_seq_detect_prog;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  seq_detect_prog_if #(.MAX_LEN(8), .LEN_W(5), .CNT_W(8)) bus ();

  seq_detect_prog #(
    .MAX_LEN(8),
    .LEN_W  (5),
    .CNT_W  (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One valid bit: y checked mid-cycle, y_q checked just after the edge.
  task automatic drive_bit(input logic b, input logic exp_y, input string tag);
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    bus.din_valid = 1'b1;
    bus.din       = b;
    #1 check({tag, "_y"}, 32'(bus.y), 32'(exp_y));
    @(posedge clk);
    #1 check({tag, "_yq"}, 32'(bus.y_q), 32'(exp_y));
    bus.din_valid = 1'b0;
  endtask

  // n bits MSB first; hits[i] marks the bit expected to complete a match.
  task automatic stream(input logic [31:0] bits, input int n, input logic [31:0] hits,
                        input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(bits[i], hits[i], $sformatf("%s[%0d]", tag, n - 1 - i));
    end
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    bus.din_valid = 1'b0;
    #1 check({tag, "_y"}, 32'(bus.y), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [4:0] len, input logic ovl,
                           input logic dv, input logic exp_err, input string tag);
    @(negedge clk);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.din_valid   = dv;
    bus.din         = 1'b1;
    #1 check({tag, "_y"}, 32'(bus.y), 32'd0);
    @(posedge clk);
    #1 check({tag, "_err"}, 32'(bus.cfg_err), 32'(exp_err));
    if (!exp_err) check({tag, "_cnt"}, 32'(bus.match_count), 32'd0);
    bus.cfg_we    = 1'b0;
    bus.din_valid = 1'b0;
    idle({tag, "_after"});
    check({tag, "_err_drop"}, 32'(bus.cfg_err), 32'd0);
  endtask

  // Reset held one cycle while an illegal write and a valid bit are offered.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst           = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_len   = 5'd1;
    bus.din_valid = 1'b1;
    bus.din       = 1'b1;
    #1 check({tag, "_y"}, 32'(bus.y), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst           = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    check({tag, "_cnt"}, 32'(bus.match_count), 32'd0);
    check({tag, "_yq"}, 32'(bus.y_q), 32'd0);
    check({tag, "_err"}, 32'(bus.cfg_err), 32'd0);
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst             = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.din_valid   = 1'b0;
    bus.din         = 1'b0;
    @(posedge clk);
    apply_reset("rst0");

    // Default 1101 overlapping: matches on bits 4 and 7.
    stream(32'b1101101, 7, 32'b0001001, "dflt");
    check("dflt_cnt", 32'(bus.match_count), 32'd2);

    // Non-overlapping 1101: only the first match counts.
    cfg_write(8'b0000_1101, 5'd4, 1'b0, 1'b0, 1'b0, "cfg_novl");
    stream(32'b1101101, 7, 32'b0001000, "novl");
    check("novl_cnt", 32'(bus.match_count), 32'd1);

    // Full-width pattern A5: matches on bits 8 and 16 of A5A5.
    cfg_write(8'hA5, 5'd8, 1'b1, 1'b0, 1'b0, "cfg_a5");
    stream(32'hA5A5, 16, 32'h0101, "a5");
    check("a5_cnt", 32'(bus.match_count), 32'd2);

    // Illegal writes in the middle of a pattern keep config and history.
    apply_reset("rst1");
    stream(32'b11, 2, 32'b00, "ill_pre");
    cfg_write(8'hFF, 5'd1, 1'b0, 1'b0, 1'b1, "ill_len1");
    cfg_write(8'h00, 5'd9, 1'b0, 1'b0, 1'b1, "ill_len9");
    stream(32'b01, 2, 32'b01, "ill_post");
    check("ill_cnt", 32'(bus.match_count), 32'd1);

    // Write colliding with a matching bit: bit dropped, history cleared.
    apply_reset("rst2");
    stream(32'b110, 3, 32'b000, "col_pre");
    cfg_write(8'b0000_1101, 5'd4, 1'b1, 1'b1, 1'b0, "col_cfg");
    stream(32'b11101, 5, 32'b00001, "col_post");
    check("col_cnt", 32'(bus.match_count), 32'd1);

    // Invalid cycles inside the pattern are transparent.
    apply_reset("rst3");
    drive_bit(1'b1, 1'b0, "gap0");
    idle("gap_i0");
    idle("gap_i1");
    drive_bit(1'b1, 1'b0, "gap1");
    idle("gap_i2");
    drive_bit(1'b0, 1'b0, "gap2");
    idle("gap_i3");
    drive_bit(1'b1, 1'b1, "gap3");
    check("gap_cnt", 32'(bus.match_count), 32'd1);

    // Reset mid-pattern: the pre-reset 110 must not complete a match.
    stream(32'b110, 3, 32'b000, "mid_pre");
    apply_reset("rst4");
    stream(32'b1101, 4, 32'b0001, "mid_post");
    check("mid_cnt", 32'(bus.match_count), 32'd1);

    // Pattern 11, all ones: every bit after the first matches; counter saturates.
    cfg_write(8'b0000_0011, 5'd2, 1'b1, 1'b0, 1'b0, "cfg_sat");
    for (int i = 0; i < 300; i++) begin
      drive_bit(1'b1, (i > 0), $sformatf("sat[%0d]", i));
      if (i == 254) check("sat_254", 32'(bus.match_count), 32'd254);
      if (i == 255) check("sat_255", 32'(bus.match_count), 32'd255);
    end
    check("sat_hold", 32'(bus.match_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter MAX_LEN, default 8, SHALL set the maximum pattern length in bits (legal range 2..16).
REQ-002 Parameter LEN_W, default 5, SHALL set the width of cfg_len (LEN_W >= clog2(MAX_LEN+1)).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of match_count.
REQ-004 Parameter DEF_PATTERN, default 8'b0000_1101, SHALL set the pattern loaded at reset, right-aligned.
REQ-005 Parameter DEF_LEN, default 4, SHALL set the pattern length loaded at reset.
REQ-006 Parameter DEF_OVERLAP, default 1, SHALL set the overlap mode loaded at reset.
REQ-007 clk  input  1  SHALL be the clock; all state updates occur on the rising edge.
REQ-008 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-009 cfg_we  input  1  SHALL request a configuration write when high.
REQ-010 cfg_pattern  input  MAX_LEN  SHALL carry the new pattern, right-aligned; bit [len-1] is the first bit expected on the serial input.
REQ-011 cfg_len  input  LEN_W  SHALL carry the new pattern length.
REQ-012 cfg_overlap  input  1  SHALL select the overlap mode: 1 = overlapping, 0 = non-overlapping.
REQ-013 din_valid  input  1  SHALL qualify din; bits with din_valid low are ignored.
REQ-014 din  input  1  SHALL carry one serial data bit per valid cycle.
REQ-015 y  output  1  SHALL be the combinational Mealy match pulse.
REQ-016 y_q  output  1  SHALL be y registered (one-cycle-delayed Moore-style copy).
REQ-017 cfg_err  output  1  SHALL be a one-cycle registered pulse flagging a rejected configuration write.
REQ-018 match_count  output  CNT_W  SHALL hold the number of matches since reset or the last configuration write.

Function
REQ-019 The block SHALL keep a history shift register hist[MAX_LEN-1:0] and a fill counter fill (0..MAX_LEN).
- On each accepted bit: hist <= {hist[MAX_LEN-2:0], din}; fill increments, saturating at MAX_LEN.
REQ-020 y SHALL be 1 when all of the following hold: din_valid=1, cfg_we=0, fill >= len-1, and {hist[len-2:0], din} == pattern[len-1:0].
REQ-021 On a match in overlapping mode, the history SHALL update normally (for example, with 1101, the stream 1101101 yields 2 matches).
REQ-022 On a match in non-overlapping mode, fill SHALL clear to 0 so that no bit of a matched pattern is reused (1101101 yields 1 match).
REQ-023 y_q SHALL equal y from the previous cycle.
REQ-024 match_count SHALL increment by 1 on each cycle with y=1 and saturate at 2^CNT_W-1.
REQ-025 A configuration write is legal only when 2 <= cfg_len <= MAX_LEN.
REQ-026 A legal configuration write SHALL, on the next edge: latch the pattern, length and overlap mode; clear hist, fill and match_count.
REQ-027 An illegal configuration write SHALL leave all configuration and history unchanged and assert cfg_err for exactly one cycle.
REQ-028 When cfg_we and din_valid are both high, cfg_we SHALL take priority: the din bit is dropped and y=0.
REQ-029 Pattern bits above len-1 SHALL be ignored in the comparison.
REQ-030 Cycles with din_valid low SHALL leave hist, fill and match_count unchanged, and y SHALL be 0.

Reset
REQ-031 While rst is high, the block SHALL load pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
REQ-032 While rst is high, the block SHALL set hist=0, fill=0, match_count=0, y_q=0 and cfg_err=0.
REQ-033 y SHALL be forced to 0 while rst is high.
REQ-034 rst SHALL take priority over cfg_we and din_valid, including when asserted mid-pattern.

Verification
REQ-035 Reset defaults: stream 1,1,0,1,1,0,1 -> y high on bits 4 and 7, y_q one cycle later each, match_count=2.
REQ-036 Non-overlap: write len=4, pattern=1101, overlap=0; stream 1101101 -> one y pulse; match_count=1.
REQ-037 Reprogram: write len=8, pattern=8'hA5; stream bits of 0xA5A5, MSB first -> y on bits 8 and 16.
REQ-038 Illegal config: write cfg_len=1, and separately cfg_len=MAX_LEN+1 -> cfg_err pulses once per write; the default 1101 pattern still detects.
REQ-039 Simultaneous events: cfg_we with din_valid=1 -> bit dropped, y=0, history cleared.
REQ-040 Valid gaps and reset: din_valid gaps inside 1101 -> still one match; rst mid-pattern -> no match until a full fresh 1101 arrives; count saturates at 255 with CNT_W=8.
